// File: rtl/lcd12864_bus_reader_if.sv
// Request/response and LCD pin bundle for the 12864 (ST7920) bus reader.
// slave: the reader engine. master: the requester plus the pad/LCD environment.
// The timeout strobe exists only when LCD_BUSY_WAIT_EN is defined.
interface lcd12864_bus_reader_if;
  // requester side
  logic       req;
  logic       req_rs;
  // LCD pins
  logic [7:0] lcd_dat_in;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_dat_oe;
  // result side
  logic       bus_busy;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       bf;
  logic [6:0] ac;
`ifdef LCD_BUSY_WAIT_EN
  logic       timeout;

  modport slave (
    input  req, req_rs, lcd_dat_in,
    output lcd_rs, lcd_rw, lcd_en, lcd_dat_oe,
    output bus_busy, rd_valid, rd_data, bf, ac, timeout
  );

  modport master (
    output req, req_rs, lcd_dat_in,
    input  lcd_rs, lcd_rw, lcd_en, lcd_dat_oe,
    input  bus_busy, rd_valid, rd_data, bf, ac, timeout
  );
`else
  modport slave (
    input  req, req_rs, lcd_dat_in,
    output lcd_rs, lcd_rw, lcd_en, lcd_dat_oe,
    output bus_busy, rd_valid, rd_data, bf, ac
  );

  modport master (
    output req, req_rs, lcd_dat_in,
    input  lcd_rs, lcd_rw, lcd_en, lcd_dat_oe,
    input  bus_busy, rd_valid, rd_data, bf, ac
  );
`endif
endinterface

// File: rtl/lcd12864_bus_reader.sv
// Read-side engine for the ST7920 8-bit parallel bus: status reads (BF/AC) and RAM data reads.
// Latency req->rd_valid: 2+SETUP+EN_HIGH+HOLD cycles (58 default), plus one extra bus cycle per dummy read.
// No backpressure: req is only sampled while bus_busy=0; a req during a transaction is dropped.
// Optional macro LCD_BUSY_WAIT_EN: data reads poll status until BF=0 first, with a POLL_MAX timeout.
module lcd12864_bus_reader #(
  parameter int SETUP_CYC   = 8,
  parameter int EN_HIGH_CYC = 40,
  parameter int HOLD_CYC    = 8,
  parameter int DUMMY_READ  = 1,
  parameter int POLL_MAX    = 255
) (
  input logic                   clk,
  input logic                   rst_n,
  lcd12864_bus_reader_if.slave  bus
);

  // Zero-length phases behave as one cycle so en timing never collapses.
  localparam int S_N   = (SETUP_CYC   < 1) ? 1 : SETUP_CYC;
  localparam int E_N   = (EN_HIGH_CYC < 1) ? 1 : EN_HIGH_CYC;
  localparam int H_N   = (HOLD_CYC    < 1) ? 1 : HOLD_CYC;
  localparam int SE_N  = (S_N > E_N) ? S_N : E_N;
  localparam int MAX_N = (SE_N > H_N) ? SE_N : H_N;
  localparam int CW    = (MAX_N < 2) ? 1 : $clog2(MAX_N);

  localparam logic [CW-1:0] S_LAST  = CW'(S_N - 1);
  localparam logic [CW-1:0] E_LAST  = CW'(E_N - 1);
  localparam logic [CW-1:0] H_LAST  = CW'(H_N - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

`ifdef LCD_BUSY_WAIT_EN
  localparam int P_N = (POLL_MAX < 1) ? 1 : POLL_MAX;
  localparam int PW  = (P_N < 2) ? 1 : $clog2(P_N);
  localparam logic [PW-1:0] P_LAST  = PW'(P_N - 1);
  localparam logic [PW-1:0] P_ONE   = PW'(1);
`endif

  // Negative cycle counts are a configuration error, not something to round.
  if (SETUP_CYC < 0 || EN_HIGH_CYC < 0 || HOLD_CYC < 0 || DUMMY_READ < 0 || POLL_MAX < 0) begin : g_param_check
    $error("lcd12864_bus_reader: parameters must be non-negative");
  end

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_EN_HI = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          rs_q;
  logic          rw_q;
  logic          en_q;
  logic          busy_q;
  logic          vld_q;
  logic [7:0]    data_q;
  logic          bf_q;
  logic [6:0]    ac_q;
  logic [7:0]    shadow;
  logic          typ_q;           // latched req_rs: 0 status, 1 data
  logic          dummy_pending;   // next completed bus cycle is a discarded RAM pre-read
`ifdef LCD_BUSY_WAIT_EN
  logic          polling;         // data read is still waiting for BF=0
  logic [PW-1:0] poll_cnt;
  logic          tout_q;
`endif

  // Sequencer: walks SETUP -> EN_HI -> HOLD for each bus cycle and publishes results.
  // rs/rw only ever change in IDLE, at the end of HOLD, or in DONE, so they are
  // stable whenever en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      rs_q          <= 1'b0;
      rw_q          <= 1'b0;
      en_q          <= 1'b0;
      busy_q        <= 1'b0;
      vld_q         <= 1'b0;
      data_q        <= 8'h00;
      bf_q          <= 1'b1;
      ac_q          <= 7'h00;
      shadow        <= 8'h00;
      typ_q         <= 1'b0;
      dummy_pending <= 1'b0;
`ifdef LCD_BUSY_WAIT_EN
      polling       <= 1'b0;
      poll_cnt      <= '0;
      tout_q        <= 1'b0;
`endif
    end else begin
      vld_q  <= 1'b0;
`ifdef LCD_BUSY_WAIT_EN
      tout_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (bus.req) begin
            typ_q         <= bus.req_rs;
            busy_q        <= 1'b1;
            rw_q          <= 1'b1;
            dummy_pending <= (DUMMY_READ != 0) && bus.req_rs;
`ifdef LCD_BUSY_WAIT_EN
            // Data reads start with status polls, so rs begins low for both kinds.
            rs_q          <= 1'b0;
            polling       <= bus.req_rs;
            poll_cnt      <= '0;
`else
            rs_q          <= bus.req_rs;
`endif
            state         <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (cnt == S_LAST) begin
            cnt   <= '0;
            en_q  <= 1'b1;
            state <= ST_EN_HI;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_EN_HI: begin
          // Sample on the final high cycle, when the LCD output is most settled.
          if (cnt == E_LAST) begin
            cnt    <= '0;
            shadow <= bus.lcd_dat_in;
            en_q   <= 1'b0;
            state  <= ST_HOLD;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_HOLD: begin
          if (cnt == H_LAST) begin
            cnt <= '0;
`ifdef LCD_BUSY_WAIT_EN
            if (polling) begin
              bf_q <= shadow[7];
              ac_q <= shadow[6:0];
              if (!shadow[7]) begin
                // Controller ready: switch to the RAM read (dummy cycle still pending).
                polling <= 1'b0;
                rs_q    <= 1'b1;
                state   <= ST_SETUP;
              end else if (poll_cnt == P_LAST) begin
                // Out of polls: give up without a result and release the bus.
                polling <= 1'b0;
                tout_q  <= 1'b1;
                rs_q    <= 1'b0;
                rw_q    <= 1'b0;
                busy_q  <= 1'b0;
                state   <= ST_IDLE;
              end else begin
                poll_cnt <= poll_cnt + P_ONE;
                state    <= ST_SETUP;
              end
            end else
`endif
            if (dummy_pending) begin
              // Discard the pre-read byte and run the real RAM cycle.
              dummy_pending <= 1'b0;
              state         <= ST_SETUP;
            end else begin
              vld_q  <= 1'b1;
              data_q <= shadow;
              if (!typ_q) begin
                bf_q <= shadow[7];
                ac_q <= shadow[6:0];
              end
              state <= ST_DONE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_DONE: begin
          rs_q   <= 1'b0;
          rw_q   <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          rs_q   <= 1'b0;
          rw_q   <= 1'b0;
          en_q   <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Pin and result outputs come straight from registers; the pads are never driven here.
  assign bus.lcd_rs     = rs_q;
  assign bus.lcd_rw     = rw_q;
  assign bus.lcd_en     = en_q;
  assign bus.lcd_dat_oe = 1'b0;
  assign bus.bus_busy   = busy_q;
  assign bus.rd_valid   = vld_q;
  assign bus.rd_data    = data_q;
  assign bus.bf         = bf_q;
  assign bus.ac         = ac_q;
`ifdef LCD_BUSY_WAIT_EN
  assign bus.timeout    = tout_q;
`endif

endmodule

// File: tb/tb_lcd12864_bus_reader.sv
// Directed bench for lcd12864_bus_reader: an LCD model returns a scripted byte per en pulse,
// a monitor measures en pulses and rs/rw stability, and scenario tasks check results inline.
// Latency is counted inclusively: the req cycle is cycle 1.
module tb_lcd12864_bus_reader;

  logic clk;
  logic rst_n;

  lcd12864_bus_reader_if bus();

  lcd12864_bus_reader #(
    .SETUP_CYC  (8),
    .EN_HIGH_CYC(40),
    .HOLD_CYC   (8),
    .DUMMY_READ (1),
    .POLL_MAX   (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed;
  int total;

  // Scripted response bytes, written only by the stimulus thread.
  logic [7:0] resp [0:7];
  int         load_tag;

  // LCD model: each en rising edge presents the next scripted byte.
  int model_idx;
  int model_tag;
  initial begin
    model_idx = 0;
    model_tag = 0;
  end
  always @(posedge bus.lcd_en) begin
    if (model_tag != load_tag) begin
      model_tag = load_tag;
      model_idx = 0;
    end
    bus.lcd_dat_in = (model_idx < 8) ? resp[model_idx] : 8'h00;
    model_idx++;
  end

  // Bus monitor, sampled on the falling edge.
  int   pulses, cur_w, viol, oe_viol, rdv_cnt;
  int   w   [0:63];
  logic rsp [0:63];
  logic rwp [0:63];
  logic rs_hold, rw_hold;
`ifdef LCD_BUSY_WAIT_EN
  int   tout_cnt;
  initial tout_cnt = 0;
  always @(negedge clk) if (bus.timeout === 1'b1) tout_cnt++;
`endif
  initial begin
    pulses = 0; cur_w = 0; viol = 0; oe_viol = 0; rdv_cnt = 0;
  end
  always @(negedge clk) begin
    if (bus.lcd_dat_oe !== 1'b0) oe_viol++;
    if (bus.rd_valid === 1'b1) rdv_cnt++;
    if (bus.lcd_en === 1'b1) begin
      if (cur_w == 0) begin
        rs_hold = bus.lcd_rs;
        rw_hold = bus.lcd_rw;
      end else if (bus.lcd_rs !== rs_hold || bus.lcd_rw !== rw_hold) begin
        viol++;
      end
      cur_w++;
    end else if (cur_w != 0) begin
      if (pulses < 64) begin
        w[pulses]   = cur_w;
        rsp[pulses] = rs_hold;
        rwp[pulses] = rw_hold;
      end
      pulses++;
      cur_w = 0;
    end
  end

  task automatic set_resp(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    resp[0] = b0; resp[1] = b1; resp[2] = b2;
    resp[3] = b3; resp[4] = b4; resp[5] = b5;
    resp[6] = 8'h00; resp[7] = 8'h00;
    load_tag++;
  endtask

  // Issue one req and wait (bounded) for rd_valid; n is the inclusive cycle count.
  task automatic run_read(input logic rs, output int n, output bit ok);
    @(negedge clk);
    bus.req    = 1'b1;
    bus.req_rs = rs;
    n  = 1;
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(posedge clk); #1;
      bus.req = 1'b0;
      n++;
      if (bus.rd_valid === 1'b1) ok = 1'b1;
    end
    total++;
    if (!ok) $display("FAIL read_complete: no rd_valid after %0d cycles, expected one", n);
    else passed++;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    total++; if (bus.lcd_rs !== 1'b0) $display("FAIL reset_rs: got %b want 0", bus.lcd_rs); else passed++;
    total++; if (bus.lcd_rw !== 1'b0) $display("FAIL reset_rw: got %b want 0", bus.lcd_rw); else passed++;
    total++; if (bus.lcd_en !== 1'b0) $display("FAIL reset_en: got %b want 0", bus.lcd_en); else passed++;
    total++; if (bus.lcd_dat_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", bus.lcd_dat_oe); else passed++;
    total++; if (bus.bus_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.bus_busy); else passed++;
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.rd_valid); else passed++;
    total++; if (bus.rd_data !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.rd_data); else passed++;
    total++; if (bus.bf !== 1'b1) $display("FAIL reset_bf: got %b want 1", bus.bf); else passed++;
    total++; if (bus.ac !== 7'h00) $display("FAIL reset_ac: got %h want 00", bus.ac); else passed++;
  endtask

  task automatic test_status_read;
    int n; bit ok; int b;
    set_resp(8'h85, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    b = pulses;
    run_read(1'b0, n, ok);
    total++; if (n !== 58) $display("FAIL status_latency: got %0d want 58", n); else passed++;
    total++; if (bus.rd_data !== 8'h85) $display("FAIL status_data: got %h want 85", bus.rd_data); else passed++;
    total++; if (bus.bf !== 1'b1) $display("FAIL status_bf: got %b want 1", bus.bf); else passed++;
    total++; if (bus.ac !== 7'h05) $display("FAIL status_ac: got %h want 05", bus.ac); else passed++;
    total++; if (bus.bus_busy !== 1'b1) $display("FAIL status_busy_at_valid: got %b want 1", bus.bus_busy); else passed++;
    @(posedge clk); #1;
    total++; if (bus.bus_busy !== 1'b0) $display("FAIL status_busy_after: got %b want 0", bus.bus_busy); else passed++;
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL status_valid_pulse: got %b want 0", bus.rd_valid); else passed++;
    total++; if (bus.lcd_rw !== 1'b0) $display("FAIL status_rw_release: got %b want 0", bus.lcd_rw); else passed++;
    total++; if (pulses - b !== 1) $display("FAIL status_en_pulses: got %0d want 1", pulses - b); else passed++;
    total++; if (w[b] !== 40) $display("FAIL status_en_width: got %0d want 40", w[b]); else passed++;
    total++; if (rsp[b] !== 1'b0 || rwp[b] !== 1'b1) $display("FAIL status_rs_rw: got rs=%b rw=%b want rs=0 rw=1", rsp[b], rwp[b]); else passed++;
  endtask

  task automatic test_data_read;
    int n; bit ok; int b;
    set_resp(8'hFF, 8'h3A, 8'h00, 8'h00, 8'h00, 8'h00);
    b = pulses;
    run_read(1'b1, n, ok);
    total++; if (n !== 114) $display("FAIL data_latency: got %0d want 114", n); else passed++;
    total++; if (bus.rd_data !== 8'h3A) $display("FAIL data_byte: got %h want 3a", bus.rd_data); else passed++;
    total++; if (bus.bf !== 1'b1) $display("FAIL data_bf_kept: got %b want 1", bus.bf); else passed++;
    total++; if (bus.ac !== 7'h05) $display("FAIL data_ac_kept: got %h want 05", bus.ac); else passed++;
    total++; if (pulses - b !== 2) $display("FAIL data_en_pulses: got %0d want 2", pulses - b); else passed++;
    total++; if (w[b] !== 40) $display("FAIL data_width0: got %0d want 40", w[b]); else passed++;
    total++; if (w[b+1] !== 40) $display("FAIL data_width1: got %0d want 40", w[b+1]); else passed++;
    total++; if (rsp[b] !== 1'b1 || rsp[b+1] !== 1'b1) $display("FAIL data_rs: got %b%b want 11", rsp[b], rsp[b+1]); else passed++;
    @(posedge clk); #1;
    total++; if (bus.bus_busy !== 1'b0 || bus.lcd_rs !== 1'b0) $display("FAIL data_release: got busy=%b rs=%b want 0 0", bus.bus_busy, bus.lcd_rs); else passed++;
  endtask

  task automatic test_back_to_back;
    int b; int rb;
    set_resp(8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    b  = pulses;
    rb = rdv_cnt;
    @(negedge clk); bus.req = 1'b1; bus.req_rs = 1'b0;
    @(negedge clk); bus.req = 1'b0;
    repeat (20) @(negedge clk);
    bus.req = 1'b1; bus.req_rs = 1'b1;
    @(negedge clk); bus.req = 1'b0; bus.req_rs = 1'b0;
    repeat (150) @(negedge clk);
    total++; if (rdv_cnt - rb !== 1) $display("FAIL b2b_valid_count: got %0d want 1", rdv_cnt - rb); else passed++;
    total++; if (pulses - b !== 1) $display("FAIL b2b_en_pulses: got %0d want 1", pulses - b); else passed++;
    total++; if (bus.bus_busy !== 1'b0) $display("FAIL b2b_idle: got %b want 0", bus.bus_busy); else passed++;
    total++; if (bus.rd_data !== 8'h12) $display("FAIL b2b_data: got %h want 12", bus.rd_data); else passed++;
    total++; if (bus.bf !== 1'b0) $display("FAIL b2b_bf: got %b want 0", bus.bf); else passed++;
    total++; if (bus.ac !== 7'h12) $display("FAIL b2b_ac: got %h want 12", bus.ac); else passed++;
    total++; if (viol !== 0) $display("FAIL rs_rw_stable: got %0d changes want 0", viol); else passed++;
    total++; if (oe_viol !== 0) $display("FAIL dat_oe_low: got %0d nonzero samples want 0", oe_viol); else passed++;
  endtask

  task automatic test_reset_mid;
    int n; bit ok; bit seen; int rb;
    set_resp(8'hFF, 8'h3A, 8'h00, 8'h00, 8'h00, 8'h00);
    rb = rdv_cnt;
    @(negedge clk); bus.req = 1'b1; bus.req_rs = 1'b1;
    @(negedge clk); bus.req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.lcd_en === 1'b1) seen = 1'b1;
    end
    repeat (10) @(negedge clk);
    total++; if (bus.lcd_en !== 1'b1) $display("FAIL rstmid_en_before: got %b want 1", bus.lcd_en); else passed++;
    #1 rst_n = 1'b0;
    #1;
    total++; if (bus.lcd_en !== 1'b0) $display("FAIL rstmid_en: got %b want 0", bus.lcd_en); else passed++;
    total++; if (bus.lcd_rw !== 1'b0) $display("FAIL rstmid_rw: got %b want 0", bus.lcd_rw); else passed++;
    total++; if (bus.lcd_rs !== 1'b0) $display("FAIL rstmid_rs: got %b want 0", bus.lcd_rs); else passed++;
    total++; if (bus.bus_busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.bus_busy); else passed++;
    total++; if (bus.bf !== 1'b1) $display("FAIL rstmid_bf: got %b want 1", bus.bf); else passed++;
    total++; if (bus.ac !== 7'h00) $display("FAIL rstmid_ac: got %h want 00", bus.ac); else passed++;
    @(negedge clk); rst_n = 1'b1;
    repeat (150) @(negedge clk);
    total++; if (rdv_cnt - rb !== 0) $display("FAIL rstmid_no_valid: got %0d want 0", rdv_cnt - rb); else passed++;
    set_resp(8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    run_read(1'b0, n, ok);
    total++; if (n !== 58) $display("FAIL rstmid_latency: got %0d want 58", n); else passed++;
    total++; if (bus.rd_data !== 8'h07) $display("FAIL rstmid_data: got %h want 07", bus.rd_data); else passed++;
    total++; if (bus.bf !== 1'b0 || bus.ac !== 7'h07) $display("FAIL rstmid_bf_ac: got %b/%h want 0/07", bus.bf, bus.ac); else passed++;
    @(posedge clk); #1;
  endtask

`ifdef LCD_BUSY_WAIT_EN
  task automatic test_busy_wait;
    int n; bit ok; int b;
    set_resp(8'h80, 8'h81, 8'h82, 8'h03, 8'hFF, 8'h41);
    b = pulses;
    run_read(1'b1, n, ok);
    total++; if (n !== 338) $display("FAIL bw_latency: got %0d want 338", n); else passed++;
    total++; if (bus.rd_data !== 8'h41) $display("FAIL bw_data: got %h want 41", bus.rd_data); else passed++;
    total++; if (bus.bf !== 1'b0 || bus.ac !== 7'h03) $display("FAIL bw_bf_ac: got %b/%h want 0/03", bus.bf, bus.ac); else passed++;
    total++; if (pulses - b !== 6) $display("FAIL bw_pulses: got %0d want 6", pulses - b); else passed++;
    total++; if ({rsp[b], rsp[b+1], rsp[b+2], rsp[b+3], rsp[b+4], rsp[b+5]} !== 6'b000011)
      $display("FAIL bw_rs_seq: got %b%b%b%b%b%b want 000011", rsp[b], rsp[b+1], rsp[b+2], rsp[b+3], rsp[b+4], rsp[b+5]);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    int b; int rb; int tb0; bit seen;
    set_resp(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
    b = pulses; rb = rdv_cnt; tb0 = tout_cnt;
    @(negedge clk); bus.req = 1'b1; bus.req_rs = 1'b1;
    @(negedge clk); bus.req = 1'b0; bus.req_rs = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.timeout === 1'b1) seen = 1'b1;
    end
    total++; if (!seen) $display("FAIL to_pulse: got none want one timeout pulse"); else passed++;
    total++; if (bus.bus_busy !== 1'b0) $display("FAIL to_busy: got %b want 0", bus.bus_busy); else passed++;
    repeat (20) @(negedge clk);
    total++; if (pulses - b !== 4) $display("FAIL to_polls: got %0d want 4", pulses - b); else passed++;
    total++; if (rdv_cnt - rb !== 0) $display("FAIL to_no_valid: got %0d want 0", rdv_cnt - rb); else passed++;
    total++; if (tout_cnt - tb0 !== 1) $display("FAIL to_count: got %0d want 1", tout_cnt - tb0); else passed++;
    total++; if (bus.bf !== 1'b1 || bus.ac !== 7'h00) $display("FAIL to_bf_ac: got %b/%h want 1/00", bus.bf, bus.ac); else passed++;
  endtask
`endif

  initial begin
    passed     = 0;
    total      = 0;
    load_tag   = 0;
    rst_n      = 1'b0;
    bus.req    = 1'b0;
    bus.req_rs = 1'b0;
    repeat (3) @(posedge clk);
    test_reset;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_status_read;
    test_data_read;
    test_back_to_back;
    test_reset_mid;
`ifdef LCD_BUSY_WAIT_EN
    test_busy_wait;
    test_timeout;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
